intr_flag_ctrl: RTL and testbench
=================================

// Module: intr_flag_ctrl
// PURPOSE
//  Interrupt/flag-context stage directly downstream of the C/Z flag register.
//  Detects external interrupt requests, owns the interrupt-enable flag I_FLG, and
//  snapshots C_FLG/Z_FLG into shadow registers on interrupt entry. It presents
//  the snapshot back for restore on RETI. Sits between the flag register and the
//  control-unit FSM.
// PARAMETERS
//  CNT_W    4   width of saturating dropped-interrupt counter DROP_CNT
// PORTS
//  CLK       in   1      system clock, all state updates on posedge
//  RST_N     in   1      asynchronous, active-low reset
//  INTR      in   1      external interrupt request, rising-edge significant
//  I_SET     in   1      SEI: set I_FLG
//  I_CLR     in   1      CLI: clear I_FLG
//  INT_ACK   in   1      control unit entering interrupt cycle (1-cycle pulse)
//  RETI      in   1      return-from-interrupt (1-cycle pulse)
//  I_RESTORE in   1      value I_FLG takes on RETI (1=RETIE, 0=RETID)
//  C_FLG     in   1      current carry flag from flag register
//  Z_FLG     in   1      current zero flag from flag register
//  INT_REQ   out  1      interrupt request to control unit
//  I_FLG     out  1      interrupt enable flag
//  SHAD_C    out  1      shadowed carry flag
//  SHAD_Z    out  1      shadowed zero flag
//  FLG_RESTORE out 1     1-cycle pulse: flag register reloads C/Z from SHAD_C/SHAD_Z
//  DROP_CNT  out  CNT_W  count of edges lost while pending already set (saturates)
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE; I_FLG, SHAD_C, SHAD_Z, INT_REQ, FLG_RESTORE,
//   pending, edge-detect history, DROP_CNT all 0. Reset mid-service aborts service.
//  Edge detect: edge = INTR & ~INTR_prev (registered). An edge sets pending.
//   If pending is already 1, DROP_CNT increments and saturates at 2^CNT_W-1.
//  I_FLG: I_SET has priority over I_CLR when both are asserted. Set/clear are
//   ignored in SERVICE, where I_FLG is forced to 0.
//  FSM states: IDLE, PEND, SERVICE.
//   IDLE->PEND: pending & I_FLG. INT_REQ=1 registered, one cycle after entry
//    condition.
//   PEND: INT_REQ held at 1 until INT_ACK. Latency from edge to INT_REQ is 2
//    cycles (no sync).
//   PEND->SERVICE on INT_ACK, same edge: SHAD_C<=C_FLG, SHAD_Z<=Z_FLG, I_FLG<=0,
//    pending<=0, INT_REQ<=0.
//   PEND->IDLE if I_CLR asserted before INT_ACK. Request is withdrawn and
//    pending is kept.
//   SERVICE->IDLE on RETI: I_FLG<=I_RESTORE, FLG_RESTORE=1 for exactly one cycle.
//    Shadow values persist.
//   Pending set during SERVICE is retained. If I_RESTORE=1, PEND is entered on
//    the cycle after RETI.
//  Ignored inputs: INT_ACK outside PEND; RETI outside SERVICE (no pulse, no change).
//  Simultaneous edge+INT_ACK: the new edge sets pending after the clear, so it
//   is kept, not lost.
// CONFIGURATION
//  INTR_SYNC_EN defined: INTR passes through a 2-flop synchronizer before edge
//   detect, so edge-to-INT_REQ latency is 4 cycles.
//  Not defined: INTR is treated as synchronous to CLK, latency 2 cycles.
//   No other difference.
// STRUCTURE
//  Package rat_intr_pkg:
//   - typedef enum logic [1:0] {IDLE, PEND, SERVICE} intr_state_t
//   - localparam DEFAULT_CNT_W = 4
//  Sub-module intr_edge_sync: optional synchronizer plus rising-edge detector,
//   1-bit in, 1-bit edge pulse out, with CLK/RST_N.
//  FSM, I_FLG, shadow registers and counter live in intr_flag_ctrl.
// TESTING (no sync unless stated)
//  1 Reset: RST_N=0 mid-SERVICE -> all outputs 0 immediately, state IDLE after
//    release.
//  2 Basic: I_SET, INTR 0->1 at cycle 5 -> INT_REQ=1 at cycle 7. Then INT_ACK
//    with C_FLG=1, Z_FLG=0 -> SHAD_C=1, SHAD_Z=0, I_FLG=0, INT_REQ=0.
//  3 RETI with I_RESTORE=1 -> FLG_RESTORE high exactly 1 cycle, I_FLG=1.
//    Repeat with I_RESTORE=0 -> I_FLG=0.
//  4 Masked: I_FLG=0, INTR edge -> INT_REQ stays 0. Then I_SET -> INT_REQ=1 one
//    cycle later.
//  5 Overflow, CNT_W=2: 5 edges while in SERVICE -> pending=1, DROP_CNT=3
//    (saturated). RETIE -> PEND on next cycle.
//  6 Corners: I_SET&I_CLR together -> I_FLG=1. INT_ACK in IDLE and RETI in PEND
//    -> no change. With INTR_SYNC_EN, edge-to-INT_REQ = 4 cycles.

Source files
------------

// File: rtl/rat_intr_pkg.sv
// ---------------------------------------------------------------------------
// rat_intr_pkg : shared types and defaults for the interrupt/flag-context stage
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package rat_intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } intr_state_t;

  localparam int DEFAULT_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/intr_edge_sync.sv
// ---------------------------------------------------------------------------
// intr_edge_sync : rising-edge detector with optional 2-flop input
//                  synchronizer (enabled by defining INTR_SYNC_EN)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module intr_edge_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic INTR,
  output logic EDGE
);

  logic w_intr_s;
  logic r_intr_prev;

`ifdef INTR_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= INTR;
      r_sync2 <= r_sync1;
    end
  end

  assign w_intr_s = r_sync2;
`else
  assign w_intr_s = INTR;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_intr_prev <= 1'b0;
    end else begin
      r_intr_prev <= w_intr_s;
    end
  end

  assign EDGE = w_intr_s & ~r_intr_prev;

endmodule

`default_nettype wire

// File: rtl/intr_flag_ctrl.sv
// ---------------------------------------------------------------------------
// intr_flag_ctrl : interrupt request FSM, I flag, C/Z shadow context and
//                  dropped-edge counter (INTR_SYNC_EN adds input synchronizer)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module intr_flag_ctrl
  import rat_intr_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             INTR,
  input  logic             I_SET,
  input  logic             I_CLR,
  input  logic             INT_ACK,
  input  logic             RETI,
  input  logic             I_RESTORE,
  input  logic             C_FLG,
  input  logic             Z_FLG,
  output logic             INT_REQ,
  output logic             I_FLG,
  output logic             SHAD_C,
  output logic             SHAD_Z,
  output logic             FLG_RESTORE,
  output logic [CNT_W-1:0] DROP_CNT
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  intr_state_t      r_state;
  intr_state_t      w_state_nxt;
  logic             w_edge;
  logic             w_clr_eff;
  logic             w_take_ack;
  logic             w_take_reti;
  logic             w_in_service;
  logic             w_int_req;
  logic             r_pending;
  logic             r_i_flg;
  logic             r_shad_c;
  logic             r_shad_z;
  logic             r_flg_restore;
  logic [CNT_W-1:0] r_drop_cnt;

  intr_edge_sync u_edge (
    .CLK   (CLK),
    .RST_N (RST_N),
    .INTR  (INTR),
    .EDGE  (w_edge)
  );

  // SEI wins over CLI, so a clear only counts when set is absent
  assign w_clr_eff = I_CLR & ~I_SET;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_pending && r_i_flg) w_state_nxt = PEND;
      PEND: begin
        if (INT_ACK)        w_state_nxt = SERVICE;
        else if (w_clr_eff) w_state_nxt = IDLE;
      end
      SERVICE: if (RETI) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_int_req    = 1'b0;
    w_take_ack   = 1'b0;
    w_take_reti  = 1'b0;
    w_in_service = 1'b0;
    case (r_state)
      PEND: begin
        w_int_req  = 1'b1;
        w_take_ack = INT_ACK;
      end
      SERVICE: begin
        w_in_service = 1'b1;
        w_take_reti  = RETI;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pending     <= 1'b0;
      r_i_flg       <= 1'b0;
      r_shad_c      <= 1'b0;
      r_shad_z      <= 1'b0;
      r_flg_restore <= 1'b0;
      r_drop_cnt    <= '0;
    end else begin
      // An edge coinciding with the acknowledge lands after the clear
      if (w_edge)          r_pending <= 1'b1;
      else if (w_take_ack) r_pending <= 1'b0;

      if (w_edge && r_pending && !w_take_ack && (r_drop_cnt != c_cnt_max))
        r_drop_cnt <= r_drop_cnt + c_cnt_one;

      if (w_take_ack) begin
        r_shad_c <= C_FLG;
        r_shad_z <= Z_FLG;
      end

      r_flg_restore <= w_take_reti;

      if (w_take_ack)        r_i_flg <= 1'b0;
      else if (w_in_service) r_i_flg <= w_take_reti ? I_RESTORE : 1'b0;
      else if (I_SET)        r_i_flg <= 1'b1;
      else if (I_CLR)        r_i_flg <= 1'b0;
    end
  end

  assign INT_REQ     = w_int_req;
  assign I_FLG       = r_i_flg;
  assign SHAD_C      = r_shad_c;
  assign SHAD_Z      = r_shad_z;
  assign FLG_RESTORE = r_flg_restore;
  assign DROP_CNT    = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_intr_flag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_flag_ctrl : directed self-checking bench for intr_flag_ctrl (CNT_W=2)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_intr_flag_ctrl;

`ifdef INTR_SYNC_EN
  localparam int c_lat = 4;
`else
  localparam int c_lat = 2;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       INTR = 1'b0;
  logic       I_SET = 1'b0;
  logic       I_CLR = 1'b0;
  logic       INT_ACK = 1'b0;
  logic       RETI = 1'b0;
  logic       I_RESTORE = 1'b0;
  logic       C_FLG = 1'b0;
  logic       Z_FLG = 1'b0;
  logic       INT_REQ;
  logic       I_FLG;
  logic       SHAD_C;
  logic       SHAD_Z;
  logic       FLG_RESTORE;
  logic [1:0] DROP_CNT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  intr_flag_ctrl #(.CNT_W(2)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .INTR        (INTR),
    .I_SET       (I_SET),
    .I_CLR       (I_CLR),
    .INT_ACK     (INT_ACK),
    .RETI        (RETI),
    .I_RESTORE   (I_RESTORE),
    .C_FLG       (C_FLG),
    .Z_FLG       (Z_FLG),
    .INT_REQ     (INT_REQ),
    .I_FLG       (I_FLG),
    .SHAD_C      (SHAD_C),
    .SHAD_Z      (SHAD_Z),
    .FLG_RESTORE (FLG_RESTORE),
    .DROP_CNT    (DROP_CNT)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset;
    INTR = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0; RETI = 0;
    I_RESTORE = 0; C_FLG = 0; Z_FLG = 0;
    RST_N = 0;
    tick(2);
    RST_N = 1;
    tick(1);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20 && INT_REQ !== 1'b1; i++) tick(1);
    checks++;
    if (INT_REQ !== 1'b1) begin
      errors++;
      $display("FAIL %s: INT_REQ=%b required 1 (timeout)", name, INT_REQ);
    end
  endtask

  task automatic go_service(input logic c, input logic z);
    I_SET = 1; tick(1); I_SET = 0;
    INTR = 1; tick(1); INTR = 0;
    wait_req("go_service_req");
    C_FLG = c; Z_FLG = z; INT_ACK = 1; tick(1); INT_ACK = 0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({INT_REQ, I_FLG, SHAD_C, SHAD_Z, FLG_RESTORE, DROP_CNT} !== 7'b0) begin
      errors++;
      $display("FAIL reset_init: outs=%b required 0000000",
               {INT_REQ, I_FLG, SHAD_C, SHAD_Z, FLG_RESTORE, DROP_CNT});
    end
    go_service(1'b1, 1'b1);
    #2 RST_N = 0;
    #1;
    checks++;
    if ({INT_REQ, I_FLG, SHAD_C, SHAD_Z, FLG_RESTORE, DROP_CNT} !== 7'b0) begin
      errors++;
      $display("FAIL reset_async: outs=%b required 0000000",
               {INT_REQ, I_FLG, SHAD_C, SHAD_Z, FLG_RESTORE, DROP_CNT});
    end
    tick(1);
    RST_N = 1;
    tick(2);
    I_RESTORE = 1; RETI = 1; tick(1); RETI = 0;
    checks++;
    if ({FLG_RESTORE, I_FLG, INT_REQ} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: restore/iflg/req=%b required 000", {FLG_RESTORE, I_FLG, INT_REQ});
    end
  endtask

  task automatic test_basic;
    do_reset();
    I_SET = 1; tick(1); I_SET = 0;
    checks++;
    if (I_FLG !== 1'b1) begin
      errors++;
      $display("FAIL basic_iset: I_FLG=%b required 1", I_FLG);
    end
    INTR = 1;
    for (int i = 1; i < c_lat; i++) begin
      tick(1);
      checks++;
      if (INT_REQ !== 1'b0) begin
        errors++;
        $display("FAIL basic_early: cycle %0d INT_REQ=%b required 0", i, INT_REQ);
      end
    end
    tick(1);
    checks++;
    if (INT_REQ !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: INT_REQ=%b required 1", INT_REQ);
    end
    tick(2);
    checks++;
    if (INT_REQ !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold: INT_REQ=%b required 1", INT_REQ);
    end
    C_FLG = 1; Z_FLG = 0; INT_ACK = 1; tick(1); INT_ACK = 0;
    checks++;
    if ({SHAD_C, SHAD_Z, I_FLG, INT_REQ} !== 4'b1000) begin
      errors++;
      $display("FAIL basic_ack: shc/shz/iflg/req=%b required 1000", {SHAD_C, SHAD_Z, I_FLG, INT_REQ});
    end
    C_FLG = 0; Z_FLG = 1; tick(1);
    checks++;
    if ({SHAD_C, SHAD_Z} !== 2'b10) begin
      errors++;
      $display("FAIL basic_shadow_hold: shadow=%b required 10", {SHAD_C, SHAD_Z});
    end
  endtask

  task automatic test_reti;
    I_RESTORE = 1; RETI = 1; tick(1); RETI = 0;
    checks++;
    if ({FLG_RESTORE, I_FLG} !== 2'b11) begin
      errors++;
      $display("FAIL retie_pulse: restore/iflg=%b required 11", {FLG_RESTORE, I_FLG});
    end
    tick(1);
    checks++;
    if ({FLG_RESTORE, INT_REQ, SHAD_C, SHAD_Z} !== 4'b0010) begin
      errors++;
      $display("FAIL retie_after: restore/req/shc/shz=%b required 0010",
               {FLG_RESTORE, INT_REQ, SHAD_C, SHAD_Z});
    end
    INTR = 0; tick(1);
    go_service(1'b0, 1'b1);
    checks++;
    if ({SHAD_C, SHAD_Z} !== 2'b01) begin
      errors++;
      $display("FAIL reti_second_shadow: shadow=%b required 01", {SHAD_C, SHAD_Z});
    end
    I_RESTORE = 0; RETI = 1; tick(1); RETI = 0;
    checks++;
    if ({FLG_RESTORE, I_FLG} !== 2'b10) begin
      errors++;
      $display("FAIL retid_pulse: restore/iflg=%b required 10", {FLG_RESTORE, I_FLG});
    end
    tick(1);
    checks++;
    if (FLG_RESTORE !== 1'b0) begin
      errors++;
      $display("FAIL retid_one_cycle: FLG_RESTORE=%b required 0", FLG_RESTORE);
    end
    RETI = 1; tick(1); RETI = 0;
    checks++;
    if (FLG_RESTORE !== 1'b0) begin
      errors++;
      $display("FAIL reti_in_idle: FLG_RESTORE=%b required 0", FLG_RESTORE);
    end
  endtask

  task automatic test_masked;
    do_reset();
    INTR = 1; tick(1); INTR = 0;
    tick(c_lat + 2);
    checks++;
    if (INT_REQ !== 1'b0) begin
      errors++;
      $display("FAIL masked_no_req: INT_REQ=%b required 0", INT_REQ);
    end
    I_SET = 1; tick(1); I_SET = 0;
    checks++;
    if ({I_FLG, INT_REQ} !== 2'b10) begin
      errors++;
      $display("FAIL masked_iset: iflg/req=%b required 10", {I_FLG, INT_REQ});
    end
    tick(1);
    checks++;
    if (INT_REQ !== 1'b1) begin
      errors++;
      $display("FAIL masked_unmask_req: INT_REQ=%b required 1", INT_REQ);
    end
    I_CLR = 1; tick(1); I_CLR = 0;
    checks++;
    if ({I_FLG, INT_REQ} !== 2'b00) begin
      errors++;
      $display("FAIL masked_withdraw: iflg/req=%b required 00", {I_FLG, INT_REQ});
    end
    I_SET = 1; tick(1); I_SET = 0;
    tick(1);
    checks++;
    if (INT_REQ !== 1'b1) begin
      errors++;
      $display("FAIL masked_pending_kept: INT_REQ=%b required 1", INT_REQ);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    go_service(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      INTR = 1; tick(1); INTR = 0; tick(1);
    end
    tick(3);
    checks++;
    if (DROP_CNT !== 2'd1) begin
      errors++;
      $display("FAIL overflow_count1: DROP_CNT=%0d required 1", DROP_CNT);
    end
    for (int i = 0; i < 3; i++) begin
      INTR = 1; tick(1); INTR = 0; tick(1);
    end
    tick(3);
    checks++;
    if ({DROP_CNT, INT_REQ, I_FLG} !== 4'b1100) begin
      errors++;
      $display("FAIL overflow_sat: cnt/req/iflg=%b required 1100", {DROP_CNT, INT_REQ, I_FLG});
    end
    I_RESTORE = 1; RETI = 1; tick(1); RETI = 0;
    checks++;
    if ({INT_REQ, I_FLG} !== 2'b01) begin
      errors++;
      $display("FAIL overflow_reti: req/iflg=%b required 01", {INT_REQ, I_FLG});
    end
    tick(1);
    checks++;
    if (INT_REQ !== 1'b1) begin
      errors++;
      $display("FAIL overflow_repend: INT_REQ=%b required 1", INT_REQ);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    I_SET = 1; tick(1); I_SET = 0;
    INTR = 1; tick(1); INTR = 0;
    wait_req("b2b_req");
    INTR = 1;
    tick(c_lat - 2);
    INT_ACK = 1; tick(1); INT_ACK = 0; INTR = 0;
    checks++;
    if ({INT_REQ, DROP_CNT} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_ack: req/cnt=%b required 000", {INT_REQ, DROP_CNT});
    end
    I_RESTORE = 1; RETI = 1; tick(1); RETI = 0;
    tick(1);
    checks++;
    if (INT_REQ !== 1'b1) begin
      errors++;
      $display("FAIL b2b_edge_kept: INT_REQ=%b required 1", INT_REQ);
    end
  endtask

  task automatic test_corners;
    do_reset();
    I_SET = 1; I_CLR = 1; tick(1); I_SET = 0; I_CLR = 0;
    checks++;
    if (I_FLG !== 1'b1) begin
      errors++;
      $display("FAIL corner_set_clr: I_FLG=%b required 1", I_FLG);
    end
    C_FLG = 1; Z_FLG = 1; INT_ACK = 1; tick(1); INT_ACK = 0;
    checks++;
    if ({SHAD_C, SHAD_Z, I_FLG, INT_REQ} !== 4'b0010) begin
      errors++;
      $display("FAIL corner_ack_idle: shc/shz/iflg/req=%b required 0010",
               {SHAD_C, SHAD_Z, I_FLG, INT_REQ});
    end
    INTR = 1; tick(1); INTR = 0;
    wait_req("corner_req");
    I_RESTORE = 0; RETI = 1; tick(1); RETI = 0;
    checks++;
    if ({FLG_RESTORE, INT_REQ, I_FLG} !== 3'b011) begin
      errors++;
      $display("FAIL corner_reti_pend: restore/req/iflg=%b required 011",
               {FLG_RESTORE, INT_REQ, I_FLG});
    end
    INT_ACK = 1; tick(1); INT_ACK = 0;
    I_SET = 1; tick(1); I_SET = 0;
    checks++;
    if (I_FLG !== 1'b0) begin
      errors++;
      $display("FAIL corner_set_in_service: I_FLG=%b required 0", I_FLG);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reti();
    test_masked();
    test_overflow();
    test_back_to_back();
    test_corners();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
